// File: rtl/uctl_dmarx_pipe.sv
// DMA receive engine: reads endpoint data from the local buffer through the memory
// interface and forwards it, with per-beat byte enables, into the AHB-master write FIFO.
module uctl_dmarx_pipe #(
    parameter int CNTR_WD    = 20,
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int FIFO_ADR   = 4,
    parameter int MAX_OUTSTD = 2
) (
    input  logic                     core_clk,
    input  logic                     uctl_rst_n,
    input  logic                     sw_rst,
    input  logic                     sepr2dmaRx_dmaStart,
    input  logic                     sepr2dmaRx_abort,
    input  logic [CNTR_WD-1:0]       sepr2dmaRx_len,
    input  logic [ADDR_SIZE-1:0]     sepr2dmaRx_laddrIn,
    input  logic [ADDR_SIZE-1:0]     sepr2dmaRx_epStartAddr,
    input  logic [ADDR_SIZE-1:0]     sepr2dmaRx_epEndAddr,
    input  logic [ADDR_SIZE-1:0]     sepr2dmaRx_sWrAddr,
    input  logic                     sepr2dmaRx_sRdWr,
    output logic                     dmaRx2sepr_dn,
    output logic                     dmaRx2sepr_abortDn,
    output logic                     dmaRx2sepr_err,
    output logic                     dmaRx2mif_rdReq,
    output logic [ADDR_SIZE-1:0]     dmaRx2mif_Addr,
    input  logic                     mif2dmaRx_ack,
    input  logic                     mif2dmaRx_rdVal,
    input  logic [DATA_SIZE-1:0]     mif2dmaRx_data,
    output logic                     dmaRx2ahbm_stransEn,
    output logic [ADDR_SIZE-1:0]     dmaRx2ahbm_sWrAddr,
    output logic                     dmaRx2ahbm_sRdWr,
    output logic [CNTR_WD-1:0]       dmaRx2ahbm_len,
    input  logic [FIFO_ADR:0]        ahbm2dmaRx_availSpace,
    input  logic                     ahbm2dmaRx_dn,
    output logic                     dmaRx2ahbm_wr,
    output logic [DATA_SIZE-1:0]     dmaRx2ahbm_data,
    output logic [DATA_SIZE/8-1:0]   dmaRx2ahbm_be
);

    localparam int BPB = DATA_SIZE / 8;
    localparam int PW  = 3;
    localparam int CW  = (FIFO_ADR + 1 > PW) ? FIFO_ADR + 1 : PW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAITDN} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [CNTR_WD-1:0]   issCntr_q, issCntr_d;
    logic [CNTR_WD-1:0]   retCntr_q, retCntr_d;
    logic [PW-1:0]        pend_q, pend_d;
    logic                 hold_q, hold_d;

    logic                 issue;
    logic                 rdReq;
    logic                 ackEv;
    logic                 dnC, abortDnC, errC, stransC;
    logic [ADDR_SIZE:0]   addrNext;

    // A raised request is held until acked, so only RUN may start a new one.
    assign issue = (state_q == RUN) && (issCntr_q != '0)
                   && (CW'(ahbm2dmaRx_availSpace) > CW'(pend_q))
                   && (pend_q < PW'(MAX_OUTSTD));
    assign rdReq    = ~sw_rst & (issue | hold_q);
    assign ackEv    = rdReq & mif2dmaRx_ack;
    assign addrNext = {1'b0, addr_q} + (ADDR_SIZE+1)'(BPB);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        issCntr_d = issCntr_q;
        retCntr_d = retCntr_q;
        pend_d    = pend_q;
        hold_d    = rdReq & ~mif2dmaRx_ack;
        dnC       = 1'b0;
        abortDnC  = 1'b0;
        errC      = 1'b0;
        stransC   = 1'b0;

        if (ackEv) begin
            addr_d    = (addrNext > {1'b0, sepr2dmaRx_epEndAddr}) ? sepr2dmaRx_epStartAddr
                                                                 : addrNext[ADDR_SIZE-1:0];
            issCntr_d = (issCntr_q > CNTR_WD'(BPB)) ? issCntr_q - CNTR_WD'(BPB) : '0;
        end
        if (mif2dmaRx_rdVal) begin
            retCntr_d = (retCntr_q > CNTR_WD'(BPB)) ? retCntr_q - CNTR_WD'(BPB) : '0;
        end
        case ({ackEv, mif2dmaRx_rdVal})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase

        // AHB completion outranks abort, so a simultaneous abort is a normal finish.
        case (state_q)
            IDLE: begin
                if (sepr2dmaRx_dmaStart) begin
                    if (sepr2dmaRx_len == '0) begin
                        dnC = 1'b1;
                    end else begin
                        stransC   = 1'b1;
                        addr_d    = sepr2dmaRx_laddrIn;
                        issCntr_d = sepr2dmaRx_len;
                        retCntr_d = sepr2dmaRx_len;
                        state_d   = RUN;
                    end
                end
            end
            RUN, WAITDN: begin
                if (ahbm2dmaRx_dn) begin
                    dnC     = 1'b1;
                    errC    = (retCntr_q != '0) || (pend_q != '0);
                    state_d = IDLE;
                end else if (sepr2dmaRx_abort) begin
                    state_d = DRAIN;
                end else if ((state_q == RUN) && (issCntr_q == '0) && !rdReq) begin
                    state_d = WAITDN;
                end
            end
            DRAIN: begin
                if ((pend_q == '0) && !rdReq) begin
                    dnC      = 1'b1;
                    abortDnC = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge uctl_rst_n) begin
        if (!uctl_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            issCntr_q <= '0;
            retCntr_q <= '0;
            pend_q    <= '0;
            hold_q    <= 1'b0;
        end else if (sw_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            issCntr_q <= '0;
            retCntr_q <= '0;
            pend_q    <= '0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            issCntr_q <= issCntr_d;
            retCntr_q <= retCntr_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
        end
    end

    // Byte i is enabled while more than i bytes remain, which yields all ones for full beats.
    always_comb begin
        dmaRx2ahbm_be = '0;
        for (int i = 0; i < BPB; i++) begin
            dmaRx2ahbm_be[i] = mif2dmaRx_rdVal && (retCntr_q > CNTR_WD'(i));
        end
    end

    assign dmaRx2sepr_dn       = dnC & ~sw_rst;
    assign dmaRx2sepr_abortDn  = abortDnC & ~sw_rst;
    assign dmaRx2sepr_err      = errC & ~sw_rst;
    assign dmaRx2ahbm_stransEn = stransC & ~sw_rst;
    assign dmaRx2mif_rdReq     = rdReq;
    assign dmaRx2mif_Addr      = addr_q;
    assign dmaRx2ahbm_sWrAddr  = sepr2dmaRx_sWrAddr;
    assign dmaRx2ahbm_sRdWr    = sepr2dmaRx_sRdWr;
    assign dmaRx2ahbm_len      = sepr2dmaRx_len;
    assign dmaRx2ahbm_wr       = mif2dmaRx_rdVal;
    assign dmaRx2ahbm_data     = mif2dmaRx_data;

endmodule

// File: tb/tb_uctl_dmarx_pipe.sv
// Directed bench for uctl_dmarx_pipe: table of full transfers plus hand-written
// sequences for flow control, abort, early AHB completion and soft reset.
module tb_uctl_dmarx_pipe;

    logic        core_clk = 1'b0;
    logic        uctl_rst_n;
    logic        sw_rst;
    logic        dmaStart;
    logic        abort;
    logic [19:0] len;
    logic [31:0] laddr, epStart, epEnd, sWrAddr;
    logic        sRdWr;
    logic        dn, abortDn, err;
    logic        rdReq;
    logic [31:0] rdAddr;
    logic        ack, rdVal;
    logic [31:0] mifData;
    logic        stransEn;
    logic [31:0] ahbAddr;
    logic        ahbRdWr;
    logic [19:0] ahbLen;
    logic [4:0]  availSpace;
    logic        ahbDn;
    logic        wr;
    logic [31:0] wrData;
    logic [3:0]  be;

    uctl_dmarx_pipe dut (
        .core_clk               (core_clk),
        .uctl_rst_n             (uctl_rst_n),
        .sw_rst                 (sw_rst),
        .sepr2dmaRx_dmaStart    (dmaStart),
        .sepr2dmaRx_abort       (abort),
        .sepr2dmaRx_len         (len),
        .sepr2dmaRx_laddrIn     (laddr),
        .sepr2dmaRx_epStartAddr (epStart),
        .sepr2dmaRx_epEndAddr   (epEnd),
        .sepr2dmaRx_sWrAddr     (sWrAddr),
        .sepr2dmaRx_sRdWr       (sRdWr),
        .dmaRx2sepr_dn          (dn),
        .dmaRx2sepr_abortDn     (abortDn),
        .dmaRx2sepr_err         (err),
        .dmaRx2mif_rdReq        (rdReq),
        .dmaRx2mif_Addr         (rdAddr),
        .mif2dmaRx_ack          (ack),
        .mif2dmaRx_rdVal        (rdVal),
        .mif2dmaRx_data         (mifData),
        .dmaRx2ahbm_stransEn    (stransEn),
        .dmaRx2ahbm_sWrAddr     (ahbAddr),
        .dmaRx2ahbm_sRdWr       (ahbRdWr),
        .dmaRx2ahbm_len         (ahbLen),
        .ahbm2dmaRx_availSpace  (availSpace),
        .ahbm2dmaRx_dn          (ahbDn),
        .dmaRx2ahbm_wr          (wr),
        .dmaRx2ahbm_data        (wrData),
        .dmaRx2ahbm_be          (be)
    );

    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic [31:0]       laddr;
        logic [31:0]       epS;
        logic [31:0]       epE;
        logic [19:0]       len;
        logic [2:0]        n;
        logic [3:0][31:0]  addr;
        logic [3:0][3:0]   be;
    } vec_t;

    vec_t vecs[6];

    int total = 0;
    int bad   = 0;

    // Memory model state and observation logs
    int          cyc = 0;
    int          lat = 2;
    int          ackDelay = 0;
    int          reqWait = 0;
    int          dueQ[$];
    logic [31:0] addrLog[$];
    logic [3:0]  beLog[$];
    int          issuedCnt, returnedCnt, outstanding, maxPend, dnCount;
    int          stableBad, beIdleBad, lastAckWait;
    logic        lastAbortDn, lastErr;
    logic        prevWaiting;
    logic [31:0] prevAddr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearLogs();
        addrLog.delete();
        beLog.delete();
        issuedCnt   = 0;
        returnedCnt = 0;
        maxPend     = 0;
        dnCount     = 0;
        stableBad   = 0;
        beIdleBad   = 0;
        lastAckWait = -1;
        lastAbortDn = 1'b0;
        lastErr     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] la, input logic [31:0] es,
                                 input logic [31:0] ee, input logic [19:0] ln, input string name);
        @(posedge core_clk); #1;
        laddr = la; epStart = es; epEnd = ee; len = ln;
        dmaStart = 1'b1;
        #1;
        checkOutput({name, " stransEn"}, stransEn, 1);
        @(posedge core_clk); #1;
        dmaStart = 1'b0;
    endtask

    task automatic waitReturned(input int n, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            @(posedge core_clk); #1;
            if (returnedCnt >= n) break;
        end
        checkOutput({name, " beats returned"}, returnedCnt, n);
    endtask

    task automatic finishAhb(input logic expErr, input string name);
        ahbDn = 1'b1;
        #1;
        checkOutput({name, " dn"}, dn, 1);
        checkOutput({name, " err"}, err, expErr);
        checkOutput({name, " abortDn"}, abortDn, 0);
        @(posedge core_clk); #1;
        ahbDn = 1'b0;
    endtask

    // Memory interface model: acks after ackDelay waiting cycles, returns data lat cycles after ack
    initial begin
        ack = 1'b0; rdVal = 1'b0; mifData = '0;
        outstanding = 0; prevWaiting = 1'b0; prevAddr = '0;
        forever begin
            @(negedge core_clk);
            cyc++;
            if (sw_rst || !uctl_rst_n) begin
                dueQ.delete();
                outstanding = 0;
                ack = 1'b0; rdVal = 1'b0;
                prevWaiting = 1'b0; reqWait = 0;
            end else begin
                if (prevWaiting && (!rdReq || rdAddr !== prevAddr)) stableBad++;
                ack     = rdReq && (reqWait >= ackDelay);
                rdVal   = (dueQ.size() > 0) && (dueQ[0] == cyc);
                mifData = 32'hA500_0000 | cyc;
                #1;
                if (rdReq && ack) begin
                    addrLog.push_back(rdAddr);
                    dueQ.push_back(cyc + lat);
                    issuedCnt++; outstanding++;
                    lastAckWait = reqWait; reqWait = 0;
                end else if (rdReq) begin
                    reqWait++;
                end else begin
                    reqWait = 0;
                end
                if (rdVal) begin
                    void'(dueQ.pop_front());
                    beLog.push_back(be);
                    returnedCnt++; outstanding--;
                end else if (be != 4'h0) begin
                    beIdleBad++;
                end
                if (outstanding > maxPend) maxPend = outstanding;
                if (dn) begin
                    dnCount++;
                    lastAbortDn = abortDn;
                    lastErr = err;
                end
                prevWaiting = rdReq && !ack;
                prevAddr = rdAddr;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{32'h100, 32'h0,   32'hFFF, 20'd10, 3'd3,
                    {32'h0,   32'h108, 32'h104, 32'h100}, {4'h0, 4'h3, 4'hF, 4'hF}};
        vecs[1] = '{32'h208, 32'h200, 32'h20F, 20'd16, 3'd4,
                    {32'h204, 32'h200, 32'h20C, 32'h208}, {4'hF, 4'hF, 4'hF, 4'hF}};
        vecs[2] = '{32'h300, 32'h300, 32'h307, 20'd5,  3'd2,
                    {32'h0,   32'h0,   32'h304, 32'h300}, {4'h0, 4'h0, 4'h1, 4'hF}};
        vecs[3] = '{32'h40,  32'h0,   32'hFFF, 20'd4,  3'd1,
                    {32'h0,   32'h0,   32'h0,   32'h40},  {4'h0, 4'h0, 4'h0, 4'hF}};
        vecs[4] = '{32'h1F8, 32'h100, 32'h1FF, 20'd7,  3'd2,
                    {32'h0,   32'h0,   32'h1FC, 32'h1F8}, {4'h0, 4'h0, 4'h7, 4'hF}};
        vecs[5] = '{32'h20C, 32'h200, 32'h20F, 20'd2,  3'd1,
                    {32'h0,   32'h0,   32'h0,   32'h20C}, {4'h0, 4'h0, 4'h0, 4'h3}};

        uctl_rst_n = 1'b0; sw_rst = 1'b0; dmaStart = 1'b0; abort = 1'b0;
        len = '0; laddr = '0; epStart = '0; epEnd = 32'hFFFF; sWrAddr = 32'h8000_0000;
        sRdWr = 1'b1; availSpace = 5'd8; ahbDn = 1'b0;
        clearLogs();

        repeat (3) @(posedge core_clk);
        #1;
        checkOutput("reset rdReq", rdReq, 0);
        checkOutput("reset addr", rdAddr, 0);
        checkOutput("reset dn", dn, 0);
        checkOutput("reset stransEn", stransEn, 0);
        checkOutput("reset be", be, 0);
        uctl_rst_n = 1'b1;

        // Zero-length start completes in the same cycle without touching the bus
        clearLogs();
        @(posedge core_clk); #1;
        len = 20'd0; dmaStart = 1'b1;
        #1;
        checkOutput("len0 dn", dn, 1);
        checkOutput("len0 stransEn", stransEn, 0);
        checkOutput("len0 rdReq", rdReq, 0);
        checkOutput("len0 err", err, 0);
        @(posedge core_clk); #1;
        dmaStart = 1'b0;
        #1;
        checkOutput("len0 idle rdReq", rdReq, 0);
        checkOutput("len0 single pulse", dnCount, 1);

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            clearLogs();
            lat = 2; ackDelay = 0; availSpace = 5'd8;
            applyStimulus(vecs[i].laddr, vecs[i].epS, vecs[i].epE, vecs[i].len, nm);
            waitReturned(int'(vecs[i].n), 100, nm);
            finishAhb(1'b0, nm);
            checkOutput({nm, " issued"}, issuedCnt, int'(vecs[i].n));
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                checkOutput($sformatf("%s addr%0d", nm, j),
                            (j < addrLog.size()) ? addrLog[j] : 32'hxxxx_xxxx, vecs[i].addr[j]);
                checkOutput($sformatf("%s be%0d", nm, j),
                            (j < beLog.size()) ? {28'h0, beLog[j]} : 32'hxxxx_xxxx, {28'h0, vecs[i].be[j]});
            end
            checkOutput({nm, " be idle"}, beIdleBad, 0);
        end

        // FIFO space of one entry limits outstanding reads to one
        clearLogs();
        lat = 5; availSpace = 5'd1;
        applyStimulus(32'h400, 32'h0, 32'hFFFF, 20'd16, "space1");
        waitReturned(4, 200, "space1");
        finishAhb(1'b0, "space1");
        checkOutput("space1 maxPend", maxPend, 1);
        checkOutput("space1 issued", issuedCnt, 4);

        clearLogs();
        availSpace = 5'd8;
        applyStimulus(32'h400, 32'h0, 32'hFFFF, 20'd16, "space8");
        waitReturned(4, 200, "space8");
        finishAhb(1'b0, "space8");
        checkOutput("space8 maxPend", maxPend, 2);

        // Withheld ack with abort while the request waits
        clearLogs();
        lat = 2; ackDelay = 4;
        applyStimulus(32'h500, 32'h0, 32'hFFFF, 20'd16, "abort");
        @(posedge core_clk); #1;
        abort = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge core_clk); #1;
            if (dnCount > 0) break;
        end
        checkOutput("abort dn seen", dnCount, 1);
        checkOutput("abort abortDn", lastAbortDn, 1);
        checkOutput("abort err", lastErr, 0);
        checkOutput("abort issued", issuedCnt, 1);
        checkOutput("abort returned", returnedCnt, 1);
        checkOutput("abort ack wait", lastAckWait, 4);
        checkOutput("abort req stable", stableBad, 0);
        abort = 1'b0; ackDelay = 0;
        repeat (10) @(posedge core_clk);
        #1;
        checkOutput("abort no more reqs", issuedCnt, 1);

        // AHB finishes while beats are still outstanding
        clearLogs();
        lat = 2;
        applyStimulus(32'h600, 32'h0, 32'hFFFF, 20'd16, "early");
        waitReturned(3, 100, "early");
        finishAhb(1'b1, "early");
        repeat (10) @(posedge core_clk);
        #1;
        checkOutput("early late beat", returnedCnt, 4);

        // Soft reset in the middle of a transfer
        clearLogs();
        applyStimulus(32'h700, 32'h0, 32'hFFFF, 20'd16, "swrst");
        @(posedge core_clk); #1;
        sw_rst = 1'b1;
        #1;
        checkOutput("swrst gated rdReq", rdReq, 0);
        @(posedge core_clk); #1;
        sw_rst = 1'b0;
        #1;
        checkOutput("swrst rdReq", rdReq, 0);
        checkOutput("swrst addr", rdAddr, 0);
        checkOutput("swrst dn", dn, 0);
        checkOutput("swrst stransEn", stransEn, 0);
        checkOutput("swrst be", be, 0);
        clearLogs();
        applyStimulus(32'h800, 32'h0, 32'hFFFF, 20'd4, "after swrst");
        waitReturned(1, 50, "after swrst");
        finishAhb(1'b0, "after swrst");
        checkOutput("after swrst addr", (addrLog.size() > 0) ? addrLog[0] : 32'hxxxx_xxxx, 32'h800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uctl_dmarx_pipe.md
Name: uctl_dmarx_pipe

Overview:
Parametrised next-generation DMA receive engine that moves endpoint data from the local buffer, via the memory interface, into the AHB-master write FIFO. It adds configurable beat width, up to MAX_OUTSTD outstanding local reads, inclusive-end ring-buffer wrap and per-beat byte enables for partial last beats. It also supports abort and error reporting. It sits between the Rx system endpoint controller, the memory interface and the AHB master.

Parameters:
CNTR_WD, 20, width of byte-length counters
DATA_SIZE, 32, beat width in bits (32 or 64); BPB = DATA_SIZE/8 bytes per beat
ADDR_SIZE, 32, local and system address width
FIFO_ADR, 4, log2 of AHB FIFO depth; availSpace is FIFO_ADR+1 bits
MAX_OUTSTD, 2, maximum read requests acked but not yet returned (1..7)

Ports:
core_clk  in  1  clock
uctl_rst_n  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous soft reset
sepr2dmaRx_dmaStart  in  1  start; level, sampled in IDLE only
sepr2dmaRx_abort  in  1  abort request, level
sepr2dmaRx_len  in  CNTR_WD  transfer length in bytes
sepr2dmaRx_laddrIn  in  ADDR_SIZE  local start address, BPB-aligned
sepr2dmaRx_epStartAddr  in  ADDR_SIZE  ring start address, BPB-aligned
sepr2dmaRx_epEndAddr  in  ADDR_SIZE  ring last byte address, inclusive
sepr2dmaRx_sWrAddr  in  ADDR_SIZE  system write address
sepr2dmaRx_sRdWr  in  1  direction, passed through
dmaRx2sepr_dn  out  1  one-cycle done pulse
dmaRx2sepr_abortDn  out  1  qualifies dn: transfer was aborted
dmaRx2sepr_err  out  1  qualifies dn: AHB finished before all beats returned
dmaRx2mif_rdReq  out  1  local read request
dmaRx2mif_Addr  out  ADDR_SIZE  local read address
mif2dmaRx_ack  in  1  request accepted
mif2dmaRx_rdVal  in  1  read data valid; returns in request order
mif2dmaRx_data  in  DATA_SIZE  read data
dmaRx2ahbm_stransEn  out  1  one-cycle start pulse to AHB master
dmaRx2ahbm_sWrAddr  out  ADDR_SIZE  pass-through of sWrAddr
dmaRx2ahbm_sRdWr  out  1  pass-through of sRdWr
dmaRx2ahbm_len  out  CNTR_WD  pass-through of len
ahbm2dmaRx_availSpace  in  FIFO_ADR+1  free FIFO entries
ahbm2dmaRx_dn  in  1  AHB transfer complete
dmaRx2ahbm_wr  out  1  FIFO write, equals rdVal
dmaRx2ahbm_data  out  DATA_SIZE  equals mif2dmaRx_data
dmaRx2ahbm_be  out  BPB  byte enables for the current FIFO write

Behaviour:
- Reset (async, or sync on sw_rst): state IDLE. All registered outputs are 0, addr=0, counters=0, pend=0. sw_rst has priority over every other event.
- States are IDLE, RUN, DRAIN, WAITDN.
- IDLE with dmaStart=1:
  - If len=0: assert dn for one cycle (abortDn=0, err=0) and stay in IDLE.
  - Otherwise: pulse stransEn; load addr=laddrIn, issCntr=len, retCntr=len; go to RUN.
- Issue condition: issue = (issCntr!=0) & (availSpace > pend) & (pend < MAX_OUTSTD).
  - rdReq = issue | hold. hold is set when rdReq=1 and ack=0, and cleared on ack.
  - Once raised, rdReq stays high with a stable address until ack, even if issue drops.
- Ack (rdReq & ack):
  - addr += BPB. If addr+BPB > epEndAddr, addr wraps to epStartAddr instead.
  - issCntr -= BPB, saturating at 0.
  - pend += 1.
- Return (rdVal): pend -= 1. Ack and rdVal in the same cycle leave pend unchanged.
- Return byte enables:
  - If retCntr >= BPB: be = all ones. Otherwise be = low retCntr bits set (e.g. retCntr=3, BPB=4 gives be=4'b0111).
  - retCntr -= BPB on each rdVal, saturating at 0.
  - be = 0 whenever wr=0.
- RUN -> WAITDN when issCntr=0 and rdReq=0.
- RUN or WAITDN -> DRAIN when abort=1.
  - In DRAIN no new requests are issued; an already-raised request still completes its ack.
  - When pend=0 and rdReq=0: pulse dn with abortDn=1, go to IDLE. ahbm2dmaRx_dn is ignored in DRAIN.
- WAITDN with ahbm2dmaRx_dn=1: pulse dn and go to IDLE.
  - err=1 in that cycle if retCntr!=0 or pend!=0.
  - ahbm2dmaRx_dn in RUN is handled the same way, so an early finish also reports err=1.
- Width rules:
  - Address arithmetic is modulo 2^ADDR_SIZE.
  - Compare addr+BPB using ADDR_SIZE+1 bits so the wrap check cannot overflow.
  - availSpace vs pend is an unsigned compare; pend is zero-extended.
- Simultaneous events: abort in the same cycle as ahbm2dmaRx_dn in WAITDN is a normal completion, abortDn=0. dmaStart outside IDLE is ignored.
- Latency: rdReq rises the cycle after stransEn, at the earliest. wr is combinational from rdVal.

Test Plan:
- len=10, BPB=4, laddr=0x100, ample space, ack every cycle, rdVal 2 cycles later -> addresses 0x100/0x104/0x108; be = F, F, 3; dn after ahbm_dn with err=0.
- len=0 with dmaStart -> dn pulse in the same cycle, no stransEn, no rdReq.
- Ring wrap: epStart=0x200, epEnd=0x20F, laddr=0x208, len=16 -> addresses 0x208, 0x20C, 0x200, 0x204.
- availSpace=1, MAX_OUTSTD=2, rdVal delayed 5 cycles -> never more than 1 pending. Then availSpace=8 -> pend peaks at 2, never 3.
- Ack withheld 4 cycles -> rdReq and addr stable throughout. Abort asserted mid-wait -> request still acked; dn+abortDn after its rdVal; no further requests.
- ahbm_dn asserted with 1 beat still outstanding -> dn with err=1. Also: sw_rst mid-RUN -> all outputs 0 the next cycle and state IDLE.
